// File: rtl/mp64_tile_pkg.sv
// ---------------------------------------------------------------------------
// mp64_tile_pkg
// Shared definitions for the 512b tile fill path in front of mp64_sram_dp.
//   ROW_WORDS   : 64-bit lanes per 512-bit row
//   LANE_IDX_W  : width of a lane index (also the low word-address bits on
//                 port B, so lane k of a row is port-B word {row, k})
//   loader_state_e : loader FSM encoding
//   lane_select : one-hot lane decode shared with the port-B address split
// ---------------------------------------------------------------------------
package mp64_tile_pkg;

    localparam int ROW_WORDS  = 8;
    localparam int LANE_IDX_W = $clog2(ROW_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Decode a lane index into a one-hot lane strobe; lane 0 is the lowest
    // 64 bits of the row.
    function automatic logic [ROW_WORDS-1:0] lane_select(input logic [LANE_IDX_W-1:0] lane);
        logic [ROW_WORDS-1:0] sel;
        sel       = {ROW_WORDS{1'b0}};
        sel[lane] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/mp64_row_packer.sv
// ---------------------------------------------------------------------------
// mp64_row_packer
// Packs consecutive 64-bit beats into one 512-bit row buffer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears index+buffer)
//   clr_i       : return the beat index to lane 0 (buffer contents kept)
//   beat_i      : a beat is accepted this cycle; data_i goes to the current lane
//   data_i      : 64-bit beat
//   last_o      : the current lane is the final lane of the row
//   row_o       : buffer with the incoming beat already merged into its lane,
//                 so the complete row is visible in the cycle of the last beat
// ---------------------------------------------------------------------------
module mp64_row_packer
    import mp64_tile_pkg::*;
#(
    parameter int DATA_W_A = 512,
    parameter int DATA_W_B = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                beat_i,
    input  logic [DATA_W_B-1:0] data_i,
    output logic                last_o,
    output logic [DATA_W_A-1:0] row_o
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(ROW_WORDS - 1);
    localparam logic [LANE_IDX_W-1:0] LANE_ONE  = LANE_IDX_W'(1);

    logic [LANE_IDX_W-1:0] idx_q;
    logic [DATA_W_A-1:0]   buf_q;
    logic [ROW_WORDS-1:0]  lane_sel_s;
    logic [DATA_W_A-1:0]   merged_s;

    // Overlay the incoming beat onto its lane of the stored buffer.
    always_comb begin
        lane_sel_s = lane_select(idx_q);
        merged_s   = buf_q;
        for (int i = 0; i < ROW_WORDS; i++) begin
            if (lane_sel_s[i]) begin
                merged_s[i*DATA_W_B +: DATA_W_B] = data_i;
            end else begin
                merged_s[i*DATA_W_B +: DATA_W_B] = buf_q[i*DATA_W_B +: DATA_W_B];
            end
        end
    end

    // Beat index and lane buffer; the index wraps to lane 0 after the last lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= {LANE_IDX_W{1'b0}};
            buf_q <= {DATA_W_A{1'b0}};
        end else begin
            if (clr_i) begin
                idx_q <= {LANE_IDX_W{1'b0}};
            end else if (beat_i) begin
                idx_q <= idx_q + LANE_ONE;
            end else begin
                idx_q <= idx_q;
            end
            if (beat_i) begin
                buf_q <= merged_s;
            end else begin
                buf_q <= buf_q;
            end
        end
    end

    assign last_o = (idx_q == LAST_LANE);
    assign row_o  = merged_s;

endmodule

// File: rtl/mp64_tile_loader.sv
// ---------------------------------------------------------------------------
// mp64_tile_loader
// Fill engine upstream of port A of mp64_sram_dp: accepts a (row, count)
// load command, packs 8 stream beats per row and issues one full-row write
// per packed row.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : load command handshake (ready only when idle)
//   cmd_row, cmd_count    : first destination row, rows to load (0..DEPTH_A)
//   s_valid/s_ready/s_data: 64-bit beat stream
//   abort                 : cancel current load, highest priority
//   a_ce/a_we/a_addr/a_wdata : port A row write (write-only use of port A)
//   busy                  : load in progress (FILL/WRITE/DONE)
//   done                  : one-cycle completion pulse
// ---------------------------------------------------------------------------
module mp64_tile_loader
    import mp64_tile_pkg::*;
#(
    parameter int ADDR_W_A = 4,
    parameter int DATA_W_A = 512,
    parameter int DATA_W_B = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W_A-1:0] cmd_row,
    input  logic [ADDR_W_A:0]   cmd_count,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W_B-1:0] s_data,
    input  logic                abort,
    output logic                a_ce,
    output logic                a_we,
    output logic [ADDR_W_A-1:0] a_addr,
    output logic [DATA_W_A-1:0] a_wdata,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W_A:0]   CNT_ZERO = {(ADDR_W_A+1){1'b0}};
    localparam logic [ADDR_W_A:0]   CNT_ONE  = (ADDR_W_A+1)'(1);
    localparam logic [ADDR_W_A-1:0] ROW_ONE  = ADDR_W_A'(1);

    loader_state_e        state_q, state_d;
    logic [ADDR_W_A-1:0]  row_q, row_d;
    logic [ADDR_W_A:0]    rem_q, rem_d;
    logic [ADDR_W_A-1:0]  a_addr_q, a_addr_d;
    logic [DATA_W_A-1:0]  a_wdata_q, a_wdata_d;

    logic                 cmd_ready_s;
    logic                 s_ready_s;
    logic                 a_ce_s;
    logic                 done_s;
    logic                 beat_s;
    logic                 last_s;
    logic [DATA_W_A-1:0]  row_full_s;

    mp64_row_packer #(
        .DATA_W_A (DATA_W_A),
        .DATA_W_B (DATA_W_B)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_FILL),
        .beat_i (beat_s),
        .data_i (s_data),
        .last_o (last_s),
        .row_o  (row_full_s)
    );

    // Next-state and handshake logic; rst and abort override every state.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        rem_d       = rem_q;
        a_addr_d    = a_addr_q;
        a_wdata_d   = a_wdata_q;
        cmd_ready_s = 1'b0;
        s_ready_s   = 1'b0;
        a_ce_s      = 1'b0;
        done_s      = 1'b0;
        beat_s      = 1'b0;
        if (rst || abort) begin
            // Partial row discarded; ready/write/done all suppressed this cycle.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_s = 1'b1;
                    if (cmd_valid) begin
                        if (cmd_count == CNT_ZERO) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d   = cmd_row;
                            rem_d   = cmd_count;
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    s_ready_s = 1'b1;
                    if (s_valid) begin
                        beat_s = 1'b1;
                        if (last_s) begin
                            // Capture the finished row so port A sees it
                            // registered during the WRITE cycle.
                            a_addr_d  = row_q;
                            a_wdata_d = row_full_s;
                            state_d   = ST_WRITE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_WRITE: begin
                    a_ce_s = 1'b1;
                    row_d  = row_q + ROW_ONE;
                    rem_d  = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_DONE: begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, load bookkeeping and registered port A address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= {ADDR_W_A{1'b0}};
            rem_q     <= CNT_ZERO;
            a_addr_q  <= {ADDR_W_A{1'b0}};
            a_wdata_q <= {DATA_W_A{1'b0}};
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            rem_q     <= rem_d;
            a_addr_q  <= a_addr_d;
            a_wdata_q <= a_wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_s;
    assign s_ready   = s_ready_s;
    assign a_ce      = a_ce_s;
    assign a_we      = a_ce_s;
    assign a_addr    = a_addr_q;
    assign a_wdata   = a_wdata_q;
    assign done      = done_s;
    assign busy      = (state_q != ST_IDLE) && !rst;

endmodule

// File: tb/tb_mp64_tile_loader.sv
// Self-checking bench for mp64_tile_loader: expected row writes are queued as
// beats are driven and compared when port A writes.
module tb_mp64_tile_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_row;
    logic [4:0]   cmd_count;
    logic         s_valid;
    logic         s_ready;
    logic [63:0]  s_data;
    logic         abort;
    logic         a_ce;
    logic         a_we;
    logic [3:0]   a_addr;
    logic [511:0] a_wdata;
    logic         busy;
    logic         done;

    typedef struct {
        logic [3:0]   addr;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   writes_seen = 0;
    int   dones_seen = 0;
    bit   busy_expected = 1'b0;

    always #5 clk = ~clk;

    mp64_tile_loader #(
        .ADDR_W_A (4),
        .DATA_W_A (512),
        .DATA_W_B (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_row   (cmd_row),
        .cmd_count (cmd_count),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .abort     (abort),
        .a_ce      (a_ce),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .busy      (busy),
        .done      (done)
    );

    // Port A monitor: every write must match the oldest queued row.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (a_ce || a_we) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: ce=%0b we=%0b addr=%0d, no write expected", a_ce, a_we, a_addr);
            end else begin
                e = exp_q.pop_front();
                if (a_ce !== 1'b1 || a_we !== 1'b1 || a_addr !== e.addr || a_wdata !== e.data) begin
                    errors++;
                    $display("FAIL row_write: addr=%0d data=%h, expected addr=%0d data=%h",
                             a_addr, a_wdata, e.addr, e.data);
                end
            end
        end
        if (done) dones_seen++;
        if (busy_expected) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_load: busy=%b, expected 1", busy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [3:0] row, input logic [4:0] cnt);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_row   = row;
        cmd_count = cnt;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b, expected 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_timeout: s_ready=%b, expected 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
    endtask

    // Drive 8 beats base+0..base+7; optionally queue the expected row write.
    task automatic send_row(input logic [3:0] addr, input logic [63:0] base,
                            input bit gaps, input bit expect_write);
        logic [511:0] row;
        exp_t e;
        for (int w = 0; w < 8; w++) row[w*64 +: 64] = base + 64'(w);
        if (expect_write) begin
            e.addr = addr;
            e.data = row;
            exp_q.push_back(e);
        end
        for (int w = 0; w < 8; w++) begin
            send_beat(base + 64'(w));
            if (gaps && w < 7) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_row = 4'd0; cmd_count = 5'd0;
        s_valid = 1'b0; s_data = 64'd0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_ce, a_we, s_ready, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ce/we/s_ready/busy/done=%b, expected 00000", {a_ce, a_we, s_ready, busy, done});
        end
        checks++;
        if (a_addr !== 4'd0 || a_wdata !== 512'd0) begin
            errors++;
            $display("FAIL reset_port_a: addr=%0d data=%h, expected 0", a_addr, a_wdata);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: cmd_ready=%b, expected 1", cmd_ready);
        end
        tick();
    endtask

    task automatic test_single_row();
        int w0, d0;
        w0 = writes_seen; d0 = dones_seen;
        issue_cmd(4'd3, 5'd1);
        send_row(4'd3, 64'hCAFE_0000_0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (a_ce !== 1'b1 || a_addr !== 4'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_write_cycle: ce=%b addr=%0d done=%b, expected 1/3/0", a_ce, a_addr, done);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || a_ce !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b ce=%b, expected 1/0", done, a_ce);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || a_addr !== 4'd3) begin
            errors++;
            $display("FAIL single_idle: done=%b cmd_ready=%b addr=%0d, expected 0/1/3", done, cmd_ready, a_addr);
        end
        checks++;
        if (writes_seen - w0 != 1 || dones_seen - d0 != 1) begin
            errors++;
            $display("FAIL single_counts: writes=%0d dones=%0d, expected 1/1", writes_seen - w0, dones_seen - d0);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int w0;
        w0 = writes_seen;
        issue_cmd(4'd0, 5'd2);
        busy_expected = 1'b1;
        send_row(4'd0, 64'hB0B0_0000_0000_0000, 1'b1, 1'b1);
        send_row(4'd1, 64'hB1B1_0000_0000_0010, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL multi_done: done=%b, expected 1", done);
        end
        busy_expected = 1'b0;
        checks++;
        if (writes_seen - w0 != 2) begin
            errors++;
            $display("FAIL multi_write_count: writes=%0d, expected 2", writes_seen - w0);
        end
        tick();
    endtask

    task automatic test_wrap();
        int w0;
        w0 = writes_seen;
        issue_cmd(4'd15, 5'd2);
        send_row(4'd15, 64'h1111_1111_1111_1110, 1'b0, 1'b1);
        send_row(4'd0,  64'h2222_2222_2222_2220, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || writes_seen - w0 != 2) begin
            errors++;
            $display("FAIL wrap_done: done=%b writes=%0d, expected 1/2", done, writes_seen - w0);
        end
        tick();
    endtask

    task automatic test_zero_count();
        int w0;
        w0 = writes_seen;
        issue_cmd(4'd7, 5'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || s_ready !== 1'b0 || a_ce !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b s_ready=%b ce=%b cmd_ready=%b, expected 1/0/0/0",
                     done, s_ready, a_ce, cmd_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || writes_seen != w0) begin
            errors++;
            $display("FAIL zero_idle: done=%b cmd_ready=%b busy=%b writes=%0d, expected 0/1/0/%0d",
                     done, cmd_ready, busy, writes_seen, w0);
        end
        tick();
    endtask

    task automatic test_abort();
        int w0, d0;
        w0 = writes_seen; d0 = dones_seen;
        // abort after beat 5
        issue_cmd(4'd2, 5'd1);
        for (int k = 0; k < 6; k++) send_beat(64'hAB00_0000_0000_0000 + 64'(k));
        abort = 1'b1; s_valid = 1'b1; s_data = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || a_ce !== 1'b0) begin
            errors++;
            $display("FAIL abort_fill: s_ready=%b ce=%b, expected 0/0", s_ready, a_ce);
        end
        tick();
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: cmd_ready=%b busy=%b done=%b, expected 1/0/0", cmd_ready, busy, done);
        end
        tick();
        // abort coincident with WRITE
        issue_cmd(4'd4, 5'd1);
        send_row(4'd4, 64'hAC00_0000_0000_0000, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ce !== 1'b0 || a_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_write: ce=%b we=%b, expected 0/0", a_ce, a_we);
        end
        tick();
        // command presented with abort in IDLE is refused
        cmd_valid = 1'b1; cmd_row = 4'd6; cmd_count = 5'd1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_cmd: cmd_ready=%b done=%b, expected 0/0", cmd_ready, done);
        end
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || writes_seen != w0 || dones_seen != d0) begin
            errors++;
            $display("FAIL abort_no_effect: busy=%b writes=%0d dones=%0d, expected 0/%0d/%0d",
                     busy, writes_seen, dones_seen, w0, d0);
        end
        tick();
        // follow-up load starts from lane 0
        issue_cmd(4'd5, 5'd1);
        send_row(4'd5, 64'hAD00_0000_0000_0100, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || writes_seen - w0 != 1) begin
            errors++;
            $display("FAIL abort_recover: done=%b writes=%0d, expected 1/1", done, writes_seen - w0);
        end
        tick();
    endtask

    task automatic test_reset_midload();
        int w0;
        w0 = writes_seen;
        issue_cmd(4'd8, 5'd4);
        send_row(4'd8, 64'hE800_0000_0000_0000, 1'b0, 1'b1);
        send_row(4'd9, 64'hE900_0000_0000_0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) send_beat(64'hEA00_0000_0000_0000 + 64'(k));
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ce, a_we, s_ready, done, cmd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: ce/we/s_ready/done/cmd_ready=%b, expected 00000",
                     {a_ce, a_we, s_ready, done, cmd_ready});
        end
        tick();
        @(negedge clk);
        checks++;
        if (a_addr !== 4'd0 || a_wdata !== 512'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: addr=%0d busy=%b data=%h, expected 0", a_addr, busy, a_wdata);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: cmd_ready=%b, expected 1", cmd_ready);
        end
        tick();
        issue_cmd(4'd1, 5'd1);
        send_row(4'd1, 64'hF100_0000_0000_0000, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || writes_seen - w0 != 3) begin
            errors++;
            $display("FAIL rst_mid_reload: done=%b writes=%0d, expected 1/3", done, writes_seen - w0);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_abort();
        test_reset_midload();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d queued rows never written, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
